bbox_scanner: RTL and testbench
===============================

BBOX_SCANNER -- requirements
Module: bbox_scanner

Interface
REQ-001 SHALL have parameter SCREEN_W, default 320, meaning screen width in pixels, used only for clipping.
REQ-002 SHALL have parameter SCREEN_H, default 240, meaning screen height in pixels, used only for clipping.
REQ-003 SHALL have clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have in_valid  input  1  bounding box offered.
REQ-006 SHALL have in_ready  output  1  scanner able to accept a box.
REQ-007 SHALL have XMIN, XMAX, YMIN, YMAX  input  16 each  signed Q10.6 box corners, rounded to whole pixels.
REQ-008 SHALL have out_valid  input-side handshake reversed: out_valid  output  1  sample coordinate valid.
REQ-009 SHALL have out_ready  input  1  downstream accepts sample.
REQ-010 SHALL have out_x, out_y  output  16 each  signed Q10.6 sample coordinate; low 6 bits always 0.
REQ-011 SHALL have out_last  output  1  current sample is final sample of the box.
REQ-012 SHALL have box_empty  output  1  one-cycle pulse when an accepted box yields no samples.

Function
REQ-013 SHALL implement FSM states IDLE and SCAN; in_ready = 1 exactly in IDLE; out_valid = 1 exactly in SCAN.
REQ-014 SHALL accept a box on the edge where in_valid && in_ready, latching corners with input bits [5:0] forced to 0.
REQ-015 SHALL, on acceptance of a non-empty box, enter SCAN with out_x = xmin, out_y = ymin visible on the next cycle (latency 1).
REQ-016 SHALL treat a box as empty when xmin > xmax or ymin > ymax (signed compare, after clipping when enabled); an empty box stays in IDLE and pulses box_empty for one cycle.
REQ-017 SHALL advance only on out_valid && out_ready; out_x, out_y and out_last SHALL hold stable while out_valid && !out_ready.
REQ-018 SHALL traverse raster order: out_x += 64 while out_x != xmax; at out_x == xmax, out_x = xmin and out_y += 64.
REQ-019 SHALL detect row and box end by equality (out_x == xmax, out_y == ymax), never by post-increment compare, so a box ending at 32704 does not wrap.
REQ-020 SHALL assert out_last iff out_x == xmax && out_y == ymax; after its handshake, return to IDLE, with in_ready = 1 on the next cycle.
REQ-021 SHALL ignore in_valid while in SCAN; the corners are not re-latched.
REQ-022 SHALL emit exactly ((xmax-xmin)/64+1)*((ymax-ymin)/64+1) samples per non-empty box.

Reset
REQ-023 SHALL, on rst_n low, immediately set state IDLE, out_valid 0, out_last 0, box_empty 0, out_x 0, out_y 0, and latched corners 0, including mid-scan.
REQ-024 SHALL drive in_ready = 1 from the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with BBOX_CLIP_EN defined, clamp latched xmin/ymin to at least 0, xmax to at most (SCREEN_W-1)*64, and ymax to at most (SCREEN_H-1)*64 before the empty check.
REQ-026 SHALL, without BBOX_CLIP_EN, use the corners unclipped and instantiate no clamp logic.

Verification
REQ-027 SHALL test: box X 0..128, Y 64..128, out_ready = 1 -> 6 samples (0,64),(64,64),(128,64),(0,128),(64,128),(128,128), out_last on the 6th only, in_ready = 1 the next cycle.
REQ-028 SHALL test: same box, out_ready low 3 cycles while out = (64,64) -> out_x, out_y, out_last stable for all 3 cycles; sequence unchanged.
REQ-029 SHALL test: XMIN = XMAX = -64, YMIN = YMAX = 192 -> one sample (-64,192) with out_last = 1; also XMIN = XMAX = 32704 -> one sample, no wrap.
REQ-030 SHALL test: XMIN = 128, XMAX = 0 -> out_valid never 1; box_empty high exactly one cycle; in_ready stays 1.
REQ-031 SHALL test: rst_n pulsed low during the 3rd sample -> out_valid 0 asynchronously; after release, a new box scans correctly from its xmin, ymin.
REQ-032 SHALL test: X -128..64, Y 0..0 -> with BBOX_CLIP_EN, samples (0,0),(64,0); without it, four samples from -128 to 64.

Source files
------------

// File: rtl/bbox_scanner.sv
// Raster scanner: accepts a Q10.6 bounding box and streams every whole-pixel
// sample inside it in row-major order. Optional clipping via BBOX_CLIP_EN.
module bbox_scanner #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] XMIN,
  input  logic signed [15:0] XMAX,
  input  logic signed [15:0] YMIN,
  input  logic signed [15:0] YMAX,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_x,
  output logic signed [15:0] out_y,
  output logic               out_last,
  output logic               box_empty
);

  localparam logic signed [15:0] STEP = 16'sd64;

  typedef enum logic {IDLE, SCAN} state_t;
  state_t state;

  logic signed [15:0] xmin_r, xmax_r, ymax_r;
  logic signed [15:0] xmin_t, xmax_t, ymin_t, ymax_t;
  logic signed [15:0] xmin_c, xmax_c, ymin_c, ymax_c;
  logic signed [15:0] next_x, next_y;
  logic               box_is_empty, row_end, next_last, unused_bits;

  // Fractional bits are dropped so every sample lands on a whole pixel.
  assign xmin_t = {XMIN[15:6], 6'b0};
  assign xmax_t = {XMAX[15:6], 6'b0};
  assign ymin_t = {YMIN[15:6], 6'b0};
  assign ymax_t = {YMAX[15:6], 6'b0};

`ifdef BBOX_CLIP_EN
  localparam logic signed [15:0] X_LIM = 16'((SCREEN_W - 1) * 64);
  localparam logic signed [15:0] Y_LIM = 16'((SCREEN_H - 1) * 64);

  function automatic logic signed [15:0] floor_zero(input logic signed [15:0] v);
    return (v < 16'sd0) ? 16'sd0 : v;
  endfunction

  function automatic logic signed [15:0] ceil_to(input logic signed [15:0] v,
                                                  input logic signed [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign xmin_c = floor_zero(xmin_t);
  assign ymin_c = floor_zero(ymin_t);
  assign xmax_c = ceil_to(xmax_t, X_LIM);
  assign ymax_c = ceil_to(ymax_t, Y_LIM);
  assign unused_bits = ^{XMIN[5:0], XMAX[5:0], YMIN[5:0], YMAX[5:0]};
`else
  assign xmin_c = xmin_t;
  assign ymin_c = ymin_t;
  assign xmax_c = xmax_t;
  assign ymax_c = ymax_t;
  assign unused_bits = ^{XMIN[5:0], XMAX[5:0], YMIN[5:0], YMAX[5:0]}
                       ^ SCREEN_W[0] ^ SCREEN_H[0];
`endif

  assign box_is_empty = (xmin_c > xmax_c) || (ymin_c > ymax_c);

  // Row/box end is found by equality so a box touching 32704 never wraps.
  always_comb begin
    row_end = (out_x == xmax_r);
    if (row_end) begin
      next_x = xmin_r;
      next_y = out_y + STEP;
    end else begin
      next_x = out_x + STEP;
      next_y = out_y;
    end
    next_last = (next_x == xmax_r) && (next_y == ymax_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      box_empty <= 1'b0;
      out_x     <= 16'sd0;
      out_y     <= 16'sd0;
      xmin_r    <= 16'sd0;
      xmax_r    <= 16'sd0;
      ymax_r    <= 16'sd0;
    end else begin
      box_empty <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            if (box_is_empty) begin
              box_empty <= 1'b1;
            end else begin
              xmin_r    <= xmin_c;
              xmax_r    <= xmax_c;
              ymax_r    <= ymax_c;
              out_x     <= xmin_c;
              out_y     <= ymin_c;
              out_last  <= (xmin_c == xmax_c) && (ymin_c == ymax_c);
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= SCAN;
            end
          end
        end
        SCAN: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              state     <= IDLE;
            end else begin
              out_x    <= next_x;
              out_y    <= next_y;
              out_last <= next_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bbox_scanner.sv
// Directed bench for bbox_scanner; expected sample lists are written out by hand.
module tb_bbox_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, out_last, box_empty;
  logic signed [15:0] XMIN = 16'sd0, XMAX = 16'sd0, YMIN = 16'sd0, YMAX = 16'sd0;
  logic signed [15:0] out_x, out_y;

  int errors = 0;
  int checks = 0;
  int exp_x[$];
  int exp_y[$];

  always #5 clk = ~clk;

  bbox_scanner dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .XMIN(XMIN), .XMAX(XMAX), .YMIN(YMIN), .YMAX(YMAX),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_last(out_last), .box_empty(box_empty)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic want(input int x, input int y);
    exp_x.push_back(x);
    exp_y.push_back(y);
  endtask

  task automatic send_box(input int x0, input int x1, input int y0, input int y1);
    int k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    check("in_ready_wait", int'(in_ready), 1);
    XMIN = 16'(x0);
    XMAX = 16'(x1);
    YMIN = 16'(y0);
    YMAX = 16'(y1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_scan(input string tag, input int stall_at, input int stall_n);
    int n = exp_x.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, int'(out_valid), 1);
      check({tag, "_x"}, int'(out_x), exp_x[i]);
      check({tag, "_y"}, int'(out_y), exp_y[i]);
      check({tag, "_last"}, int'(out_last), (i == n - 1) ? 1 : 0);
      check({tag, "_busy"}, int'(in_ready), 0);
      if (i == stall_at) begin
        out_ready = 1'b0;
        in_valid = 1'b1;
        XMIN = 16'(-640);
        XMAX = 16'(640);
        YMIN = 16'(-640);
        YMAX = 16'(640);
        for (int s = 0; s < stall_n; s++) begin
          tick();
          check({tag, "_stall_valid"}, int'(out_valid), 1);
          check({tag, "_stall_x"}, int'(out_x), exp_x[i]);
          check({tag, "_stall_y"}, int'(out_y), exp_y[i]);
          check({tag, "_stall_last"}, int'(out_last), (i == n - 1) ? 1 : 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      tick();
    end
    check({tag, "_done_ready"}, int'(in_ready), 1);
    check({tag, "_done_valid"}, int'(out_valid), 0);
    exp_x.delete();
    exp_y.delete();
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_pulse"}, int'(box_empty), 1);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_ready"}, int'(in_ready), 1);
    tick();
    check({tag, "_pulse_end"}, int'(box_empty), 0);
    check({tag, "_ready2"}, int'(in_ready), 1);
    for (int s = 0; s < 3; s++) begin
      check({tag, "_quiet"}, int'(out_valid), 0);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_ready", int'(in_ready), 0);
    check("rst_last", int'(out_last), 0);
    check("rst_empty", int'(box_empty), 0);
    check("rst_x", int'(out_x), 0);
    check("rst_y", int'(out_y), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", int'(in_ready), 1);

    // Basic 3x2 box; XMAX carries fractional bits that must be dropped.
    send_box(0, 133, 64, 128);
    want(0, 64); want(64, 64); want(128, 64);
    want(0, 128); want(64, 128); want(128, 128);
    expect_scan("basic", -1, 0);

    // Backpressure on (64,64) with a competing box offered during the stall.
    send_box(0, 128, 64, 128);
    want(0, 64); want(64, 64); want(128, 64);
    want(0, 128); want(64, 128); want(128, 128);
    expect_scan("stall", 1, 3);

`ifdef BBOX_CLIP_EN
    send_box(-64, -64, 192, 192);
    expect_empty("neg_single");
    send_box(32704, 32704, 0, 0);
    expect_empty("edge_single");
`else
    send_box(-64, -64, 192, 192);
    want(-64, 192);
    expect_scan("neg_single", -1, 0);
    send_box(32704, 32704, 0, 0);
    want(32704, 0);
    expect_scan("edge_single", -1, 0);
`endif

    send_box(128, 0, 0, 0);
    expect_empty("empty_x");

    // Reset while the third sample is on the output.
    send_box(0, 128, 0, 64);
    check("mid_s0_x", int'(out_x), 0);
    tick();
    check("mid_s1_x", int'(out_x), 64);
    tick();
    check("mid_s2_x", int'(out_x), 128);
    check("mid_s2_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_x", int'(out_x), 0);
    check("mid_rst_last", int'(out_last), 0);
    check("mid_rst_ready", int'(in_ready), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rel_ready", int'(in_ready), 1);
    send_box(64, 128, 64, 64);
    want(64, 64); want(128, 64);
    expect_scan("after_rst", -1, 0);

    send_box(-128, 64, 0, 0);
`ifdef BBOX_CLIP_EN
    want(0, 0); want(64, 0);
`else
    want(-128, 0); want(-64, 0); want(0, 0); want(64, 0);
`endif
    expect_scan("clip_row", -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
